alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator-side controller for the registered 8-bit ALU (ports clk, A, B, opcode, ALU_Out).
- Holds a small loaded program of (opcode, immediate) instructions and issues them to the ALU one at a time.
- For each instruction, drives A = accumulator, B = immediate, and the instruction's opcode; after the ALU latency it captures ALU_Out back into the accumulator.
- Replaces hand-toggled bench stimulus with a self-timed driver for multi-step ALU sequences.

Parameters:
- DATA_W, 8, operand/accumulator width; matches ALU A/B/ALU_Out.
- DEPTH, 16, program memory entries (address width = clog2(DEPTH) = 4).
- ALU_LATENCY, 1, clock cycles from ALU inputs being sampled to ALU_Out being valid; must be ≥1.

Ports:
- clk  in  1  single system clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write enable.
- prog_addr  in  4  program write address.
- prog_data  in  12  instruction: [11:8] opcode, [7:0] immediate.
- start  in  1  begin a run; sampled only in IDLE.
- length  in  5  number of instructions to execute, 0..16; latched on start.
- init_acc  in  8  accumulator seed; latched on start.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_opcode  out  4  to ALU opcode.
- alu_out  in  8  from ALU ALU_Out.
- acc  out  8  accumulator.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse, asserted in the DONE state.

Behaviour:
- Reset (async, any time, including mid-run):
  - State→IDLE; pc, count, acc, alu_a, alu_b, alu_opcode, busy, done all 0.
  - Program memory contents are not reset.
- Program writes: prog_we in IDLE writes mem[prog_addr] ← prog_data at the clock edge. prog_we while busy is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start=1: acc ← init_acc, pc ← 0, len_q ← length.
  - If length=0 → DONE; else → ISSUE.
  - start=1 in any other state is ignored.
- ISSUE (one cycle):
  - alu_a = acc, alu_b = mem[pc][7:0], alu_opcode = mem[pc][11:8].
  - Wait counter ← 0; → WAIT.
- WAIT:
  - ALU inputs are held unchanged.
  - Counter increments each cycle.
  - When counter = ALU_LATENCY−1: acc ← alu_out, pc ← pc+1.
  - If pc+1 = len_q → DONE, else → ISSUE.
- Per-instruction cost: 1 + ALU_LATENCY cycles. A run of N instructions completes in N·(1+ALU_LATENCY) cycles, with done asserted in the following cycle.
- DONE: done=1 and busy=1 for exactly one cycle; → IDLE.
- ALU output drive: alu_a/alu_b/alu_opcode are registered, loaded when entering ISSUE, and stable through WAIT. In IDLE/DONE they are driven to 0.
- Width: acc is exactly 8 bits. Wrap-around is the ALU's result; the sequencer performs no arithmetic on data.
- pc is 5 bits internally. length > 16 is not legal input; it is clamped to 16 on latch.
- A start asserted in the same cycle the DONE state is exited is ignored (IDLE samples it next cycle).

Decomposition:
- Shared package alu_pkg:
  - Opcode constants (OP_ADD = 4'b0000 and the remaining ALU opcodes).
  - Instruction field positions (OPC_MSB/LSB, IMM_MSB/LSB).
  - Sequencer state enum {IDLE, ISSUE, WAIT, DONE}.
  - DATA_W default.
- One sub-module, alu_seq_prog_mem: DEPTH×12 register file with a synchronous write port and an asynchronous read port addressed by pc.

Test Plan (bench instantiates alu_sequencer with the existing ALU, ALU_LATENCY=1):
- Program 3× {ADD, 0x01}, init_acc=0x01, length=3, start pulse → done pulses in the 7th cycle after the start edge, acc=0x04, busy high cycles 1–7.
- {ADD, 0xFF}, init_acc=0x02, length=1 → acc=0x01 (8-bit wrap), done in the 3rd cycle, and alu_a=0x02/alu_b=0xFF stable over cycles 1–2.
- length=0, init_acc=0x5A → DONE in the cycle after start, acc=0x5A, alu_opcode never leaves 0.
- Run of 4× ADD 0x10; assert reset in the 2nd WAIT cycle → all outputs 0 immediately (asynchronous). A new run then executes the unchanged program correctly: init 0 → acc=0x40.
- During a run: start pulse plus prog_we to addr 0 with {ADD, 0x77} → both ignored, result unchanged, mem[0] still holds the original instruction.
- Program 16 entries of {ADD, 0x01}, length=16, init 0 → acc=0x10, pc wraps cleanly, done in the 33rd cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer.
// Contents: opcode encodings, instruction field layout and sequencer states.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int INSTR_W        = 12;

  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_e;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the ALU sequencer.
// Synchronous write port, asynchronous read port.
module alu_seq_prog_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [INSTR_W-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [INSTR_W-1:0]       o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Contents survive reset, so there is no reset branch here.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues a loaded (opcode, immediate) program to a registered ALU, one
// instruction at a time, feeding each result back through the accumulator.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int DEPTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_prog_we,
  input  logic [$clog2(DEPTH)-1:0] i_prog_addr,
  input  logic [INSTR_W-1:0]       i_prog_data,
  input  logic                     i_start,
  input  logic [$clog2(DEPTH):0]   i_length,
  input  logic [DATA_W-1:0]        i_init_acc,
  output logic [DATA_W-1:0]        o_alu_a,
  output logic [DATA_W-1:0]        o_alu_b,
  output logic [3:0]               o_alu_opcode,
  input  logic [DATA_W-1:0]        i_alu_out,
  output logic [DATA_W-1:0]        o_acc,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PC_W  = AW + 1;
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  seq_state_e         r_state, w_stateNext;
  logic [PC_W-1:0]    r_pc, w_pcNext, r_len, w_lenClamped;
  logic [CNT_W-1:0]   r_waitCnt;
  logic [DATA_W-1:0]  r_acc, w_accNext, r_aluA, r_aluB;
  logic [3:0]         r_aluOpc;
  logic [INSTR_W-1:0] w_instr;
  logic               w_waitDone, w_progWe;

  assign w_progWe     = i_prog_we && (r_state == IDLE);
  assign w_waitDone   = (r_state == WAIT) && (r_waitCnt == CNT_W'(ALU_LATENCY - 1));
  assign w_lenClamped = (i_length > PC_W'(DEPTH)) ? PC_W'(DEPTH) : i_length;

  // Read at the next pc so the ISSUE operands can be registered on entry.
  alu_seq_prog_mem #(.DEPTH(DEPTH)) u_progMem (
    .i_clk   (i_clk),
    .i_we    (w_progWe),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_raddr (w_pcNext[AW-1:0]),
    .o_rdata (w_instr)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_accNext   = r_acc;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_accNext   = i_init_acc;
          w_pcNext    = '0;
          w_stateNext = (i_length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: w_stateNext = WAIT;
      WAIT: begin
        if (w_waitDone) begin
          w_accNext   = i_alu_out;
          w_pcNext    = r_pc + 1'b1;
          w_stateNext = ((r_pc + 1'b1) == r_len) ? DONE : ISSUE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // ALU operands load on entry to ISSUE, hold through WAIT, clear otherwise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc      <= '0;
      r_len     <= '0;
      r_acc     <= '0;
      r_waitCnt <= '0;
      r_aluA    <= '0;
      r_aluB    <= '0;
      r_aluOpc  <= '0;
    end else begin
      r_pc  <= w_pcNext;
      r_acc <= w_accNext;
      if (r_state == IDLE && i_start) r_len <= w_lenClamped;
      if (r_state == ISSUE)     r_waitCnt <= '0;
      else if (r_state == WAIT) r_waitCnt <= r_waitCnt + 1'b1;
      if (w_stateNext == ISSUE) begin
        r_aluA   <= w_accNext;
        r_aluB   <= DATA_W'(w_instr[IMM_MSB:IMM_LSB]);
        r_aluOpc <= w_instr[OPC_MSB:OPC_LSB];
      end else if (w_stateNext != WAIT) begin
        r_aluA   <= '0;
        r_aluB   <= '0;
        r_aluOpc <= '0;
      end
    end
  end

  assign o_acc        = r_acc;
  assign o_alu_a      = r_aluA;
  assign o_alu_b      = r_aluB;
  assign o_alu_opcode = r_aluOpc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a registered 8-bit ALU model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        progWe;
  logic [3:0]  progAddr;
  logic [11:0] progData;
  logic        start;
  logic [4:0]  seqLength;
  logic [7:0]  initAcc;
  logic [7:0]  aluA, aluB, aluOut, acc;
  logic [3:0]  aluOpc;
  logic        busy, done;

  int vectorCount = 0;
  int failCount   = 0;

  logic [7:0] aSeen    [0:39];
  logic [7:0] bSeen    [0:39];
  logic [3:0] opSeen   [0:39];
  logic       busySeen [0:39];
  logic       doneSeen [0:39];

  int doneCyc, doneCnt, busyCnt, opNonZero;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_prog_we    (progWe),
    .i_prog_addr  (progAddr),
    .i_prog_data  (progData),
    .i_start      (start),
    .i_length     (seqLength),
    .i_init_acc   (initAcc),
    .o_alu_a      (aluA),
    .o_alu_b      (aluB),
    .o_alu_opcode (aluOpc),
    .i_alu_out    (aluOut),
    .o_acc        (acc),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic logic [7:0] aluFunc(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 8'h00) ? 8'h00 : a / b;
      OP_SHL:  return a << 1;
      OP_SHR:  return a >> 1;
      OP_ROL:  return {a[6:0], a[7]};
      OP_ROR:  return {a[0], a[7:1]};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      OP_GT:   return (a > b) ? 8'h01 : 8'h00;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // Registered ALU with one cycle of latency.
  always_ff @(posedge clk) aluOut <= aluFunc(aluA, aluB, aluOpc);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadProgram(input int idx, input logic [3:0] op, input logic [7:0] imm);
    @(negedge clk);
    progWe   = 1'b1;
    progAddr = 4'(idx);
    progData = {op, imm};
    @(negedge clk);
    progWe   = 1'b0;
  endtask

  // Cycle k is the k-th clock period after the edge that accepts start.
  task automatic applyStimulus(input logic [7:0] seed, input logic [4:0] len,
                               input int window, input int injectCycle);
    @(negedge clk);
    initAcc   = seed;
    seqLength = len;
    start     = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (injectCycle != 0 && k == injectCycle) begin
        start    = 1'b1;
        progWe   = 1'b1;
        progAddr = 4'd0;
        progData = {OP_ADD, 8'h77};
      end
      if (injectCycle != 0 && k == injectCycle + 1) begin
        start  = 1'b0;
        progWe = 1'b0;
      end
      aSeen[k]    = aluA;
      bSeen[k]    = aluB;
      opSeen[k]   = aluOpc;
      busySeen[k] = busy;
      doneSeen[k] = done;
    end
  endtask

  task automatic evalRun(input int window);
    doneCyc   = 0;
    doneCnt   = 0;
    busyCnt   = 0;
    opNonZero = 0;
    for (int k = 1; k <= window; k++) begin
      if (doneSeen[k]) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = k;
      end
      if (busySeen[k]) busyCnt++;
      if (opSeen[k] != 4'h0) opNonZero++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    progWe    = 1'b0;
    progAddr  = '0;
    progData  = '0;
    start     = 1'b0;
    seqLength = '0;
    initAcc   = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_acc",  32'(acc),    32'h0);
    checkOutput("rst_a",    32'(aluA),   32'h0);
    checkOutput("rst_busy", 32'(busy),   32'h0);
    checkOutput("rst_done", 32'(done),   32'h0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) loadProgram(i, OP_ADD, 8'h01);
    applyStimulus(8'h01, 5'd3, 10, 0);
    evalRun(10);
    checkOutput("t1_done_cyc", 32'(doneCyc), 32'd7);
    checkOutput("t1_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("t1_busy_cnt", 32'(busyCnt), 32'd7);
    checkOutput("t1_busy_c1",  32'(busySeen[1]), 32'd1);
    checkOutput("t1_busy_c8",  32'(busySeen[8]), 32'd0);
    checkOutput("t1_acc",      32'(acc), 32'h04);

    loadProgram(0, OP_ADD, 8'hFF);
    applyStimulus(8'h02, 5'd1, 6, 0);
    evalRun(6);
    checkOutput("t2_done_cyc", 32'(doneCyc), 32'd3);
    checkOutput("t2_acc",      32'(acc), 32'h01);
    checkOutput("t2_a_c1",     32'(aSeen[1]), 32'h02);
    checkOutput("t2_a_c2",     32'(aSeen[2]), 32'h02);
    checkOutput("t2_b_c1",     32'(bSeen[1]), 32'hFF);
    checkOutput("t2_b_c2",     32'(bSeen[2]), 32'hFF);
    checkOutput("t2_a_done",   32'(aSeen[3]), 32'h00);

    loadProgram(0, OP_SUB, 8'h03);
    loadProgram(1, OP_XOR, 8'hF0);
    loadProgram(2, OP_ADD, 8'h10);
    applyStimulus(8'h20, 5'd3, 10, 0);
    checkOutput("mix_op_c1", 32'(opSeen[1]), 32'(OP_SUB));
    checkOutput("mix_op_c3", 32'(opSeen[3]), 32'(OP_XOR));
    checkOutput("mix_a_c3",  32'(aSeen[3]),  32'h1D);
    checkOutput("mix_b_c3",  32'(bSeen[3]),  32'hF0);
    checkOutput("mix_acc",   32'(acc),       32'hFD);

    applyStimulus(8'h5A, 5'd0, 4, 0);
    evalRun(4);
    checkOutput("t3_done_cyc", 32'(doneCyc), 32'd1);
    checkOutput("t3_busy_cnt", 32'(busyCnt), 32'd1);
    checkOutput("t3_op_moves", 32'(opNonZero), 32'd0);
    checkOutput("t3_acc",      32'(acc), 32'h5A);

    for (int i = 0; i < 4; i++) loadProgram(i, OP_ADD, 8'h10);
    @(negedge clk);
    initAcc   = 8'h00;
    seqLength = 5'd4;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t4_pre_acc",  32'(acc),  32'h10);
    checkOutput("t4_pre_b",    32'(aluB), 32'h10);
    checkOutput("t4_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t4_rst_acc",  32'(acc),  32'h0);
    checkOutput("t4_rst_a",    32'(aluA), 32'h0);
    checkOutput("t4_rst_b",    32'(aluB), 32'h0);
    checkOutput("t4_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h00, 5'd4, 12, 0);
    evalRun(12);
    checkOutput("t4_rerun_acc",  32'(acc), 32'h40);
    checkOutput("t4_rerun_done", 32'(doneCyc), 32'd9);

    applyStimulus(8'h00, 5'd4, 12, 2);
    evalRun(12);
    checkOutput("t5_acc",      32'(acc), 32'h40);
    checkOutput("t5_done_cyc", 32'(doneCyc), 32'd9);
    checkOutput("t5_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("t5_idle_c11", 32'(busySeen[11]), 32'd0);
    applyStimulus(8'h00, 5'd1, 4, 0);
    checkOutput("t5_mem0", 32'(acc), 32'h10);

    for (int i = 0; i < 16; i++) loadProgram(i, OP_ADD, 8'h01);
    applyStimulus(8'h00, 5'd16, 36, 0);
    evalRun(36);
    checkOutput("t6_acc",      32'(acc), 32'h10);
    checkOutput("t6_done_cyc", 32'(doneCyc), 32'd33);
    checkOutput("t6_busy_cnt", 32'(busyCnt), 32'd33);

    applyStimulus(8'h00, 5'd20, 36, 0);
    evalRun(36);
    checkOutput("clamp_acc",      32'(acc), 32'h10);
    checkOutput("clamp_done_cyc", 32'(doneCyc), 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
